// File: rtl/dec38_pkg.sv
// dec38_pkg: shared widths and FSM state type for the registered 3-to-8 decoder.
package dec38_pkg;
    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;
    typedef enum logic {IDLE, HOLD} dec_state_t;
endpackage

// File: rtl/decoder3to8_seq_if.sv
// decoder3to8_seq_if: code-word handshake and decoded one-hot outputs.
interface decoder3to8_seq_if;
    import dec38_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic                v;
    logic [CODE_W-1:0]   y;
    logic [ONEHOT_W-1:0] o;
    logic                o_active;
    logic                done;
    logic                err;
    modport master (output in_valid, v, y, input in_ready, o, o_active, done, err);
    modport slave  (input in_valid, v, y, output in_ready, o, o_active, done, err);
endinterface

// File: rtl/dec3to8_comb.sv
// dec3to8_comb: pure combinational 3-to-8 one-hot decode.
module dec3to8_comb
    import dec38_pkg::*;
(
    input  logic [CODE_W-1:0]   y,
    output logic [ONEHOT_W-1:0] o
);
    for (genvar i = 0; i < ONEHOT_W; i++) begin : g_dec
        localparam logic [CODE_W-1:0] K = CODE_W'(i);
        assign o[i] = &(y ~^ K);
    end
endmodule

// File: rtl/decoder3to8_seq.sv
// decoder3to8_seq: registered 3-to-8 decoder holding each word HOLD_CYCLES cycles.
// Optional DEC38_ERR_EN builds the err pulse for accepted v=0 words.
module decoder3to8_seq
    import dec38_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder3to8_seq_if.slave   bus
);
    dec_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ONEHOT_W-1:0] o_q, o_d, dec;
    logic                act_q, act_d, done_q, done_d;
    logic                in_ready, load;

    dec3to8_comb u_dec (.y(bus.y), .o(dec));

    // Ready depends only on registered state, so no valid->ready loop exists.
    assign in_ready = (state_q == IDLE) || (cnt_q == '0);
    assign load     = bus.in_valid && in_ready && bus.v;

    always_comb begin
        state_d = load ? HOLD : (state_q == HOLD && cnt_q == '0) ? IDLE : state_q;
        cnt_d   = load ? CNT_W'(HOLD_CYCLES - 1) : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        o_d     = load ? dec : (state_d == IDLE) ? '0 : o_q;
        act_d   = (state_d == HOLD);
        done_d  = (state_d == HOLD) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

`ifdef DEC38_ERR_EN
    logic err_q, err_d;
    always_comb begin
        err_d = bus.in_valid && in_ready && !bus.v;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready = in_ready;
    assign bus.o        = o_q;
    assign bus.o_active = act_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_decoder3to8_seq.sv
// tb_decoder3to8_seq: scoreboard bench driving HOLD_CYCLES=4 and =1 instances with shared stimulus.
module tb_decoder3to8_seq;
`ifdef DEC38_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, v;
    logic [2:0] y;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sbq [2][$];
    int held [2];
    logic pend_err [2];

    always #5 clk = ~clk;

    decoder3to8_seq_if b4 ();
    decoder3to8_seq_if b1 ();
    assign b4.in_valid = in_valid;
    assign b4.v        = v;
    assign b4.y        = y;
    assign b1.in_valid = in_valid;
    assign b1.v        = v;
    assign b1.y        = y;

    decoder3to8_seq #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    decoder3to8_seq #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: every accepted v=1 word must appear for exactly hc cycles, in order.
    task automatic mon(input int id, input int hc, input logic [7:0] o, input logic act,
                       input logic dn, input logic rdy, input logic er);
        logic exp_act;
        exp_act = sbq[id].size() != 0;
        check($sformatf("o_active_h%0d", hc), act, exp_act);
        if (exp_act) begin
            held[id]++;
            check($sformatf("o_h%0d", hc), o, sbq[id][0]);
            check($sformatf("done_h%0d", hc), dn, held[id] == hc);
            check($sformatf("in_ready_h%0d", hc), rdy, held[id] == hc);
            if (held[id] == hc) begin
                void'(sbq[id].pop_front());
                held[id] = 0;
            end
        end else begin
            check($sformatf("o_idle_h%0d", hc), o, 8'h00);
            check($sformatf("done_idle_h%0d", hc), dn, 1'b0);
            check($sformatf("in_ready_idle_h%0d", hc), rdy, 1'b1);
        end
        check($sformatf("err_h%0d", hc), er, ERR_EN && pend_err[id]);
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && b4.in_ready && v) sbq[0].push_back(8'h01 << y);
            if (in_valid && b1.in_ready && v) sbq[1].push_back(8'h01 << y);
            pend_err[0] = in_valid && b4.in_ready && !v;
            pend_err[1] = in_valid && b1.in_ready && !v;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sbq[i].delete();
                held[i] = 0;
                pend_err[i] = 1'b0;
            end
        end else begin
            mon(0, 4, b4.o, b4.o_active, b4.done, b4.in_ready, b4.err);
            mon(1, 1, b1.o, b1.o_active, b1.done, b1.in_ready, b1.err);
        end
    end

    task automatic send(input logic [2:0] c, input logic vv);
        int n;
        n = 0;
        in_valid = 1'b1;
        v = vv;
        y = c;
        while (!b4.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sy [3];
        logic [7:0] so [3];
        sy = '{3'd1, 3'd1, 3'd4};
        so = '{8'h02, 8'h02, 8'h10};
        held = '{0, 0};
        pend_err = '{1'b0, 1'b0};
        rst_n = 1'b0;
        in_valid = 1'b0;
        v = 1'b0;
        y = 3'd0;
        #3;
        check("rst_o", b4.o, 8'h00);
        check("rst_o_active", b4.o_active, 1'b0);
        check("rst_done", b4.done, 1'b0);
        check("rst_err", b4.err, 1'b0);
        check("rst_in_ready", b4.in_ready, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(3'd5, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("y5_o", b4.o, 8'h20);
            check("y5_done", b4.done, k == 3);
            @(negedge clk);
        end
        check("y5_o_after", b4.o, 8'h00);
        check("y5_ready_after", b4.in_ready, 1'b1);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 1'b1);
            idle(6);
        end
        send(3'd2, 1'b1);
        send(3'd6, 1'b1);
        idle(8);
        send(3'd7, 1'b0);
        in_valid = 1'b0;
        check("v0_o", b4.o, 8'h00);
        check("v0_err", b4.err, ERR_EN);
        @(negedge clk);
        check("v0_err_clear", b4.err, 1'b0);
        idle(2);
        in_valid = 1'b1;
        v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            y = sy[k];
            @(negedge clk);
            check("h1_o", b1.o, so[k]);
            check("h1_ready", b1.in_ready, 1'b1);
            check("h1_done", b1.done, 1'b1);
        end
        idle(8);
        send(3'd3, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_o", b4.o, 8'h00);
        check("rst_mid_active", b4.o_active, 1'b0);
        check("rst_mid_done", b4.done, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("rst_rel_ready", b4.in_ready, 1'b1);
        @(negedge clk);
        send(3'd4, 1'b1);
        in_valid = 1'b0;
        check("post_rst_o", b4.o, 8'h10);
        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
